panel_input_conditioner: RTL

PANEL_INPUT_CONDITIONER -- requirements
Module: panel_input_conditioner

---
 rtl/panel_pkg.sv | 38 +++
 rtl/panel_input_conditioner_debounce.sv | 60 ++++++
 rtl/panel_input_conditioner.sv | 111 +++++++++++
 3 files changed

// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel input conditioner: channel indices,
// drink selection encodings and the selection state type.
package panel_pkg;

  typedef enum logic [2:0] {
    CH_M1         = 3'd0,
    CH_M2         = 3'd1,
    CH_CANCEL     = 3'd2,
    CH_EXPRESO    = 3'd3,
    CH_CAFE_LECHE = 3'd4,
    CH_CAPPU      = 3'd5,
    CH_MOCCA      = 3'd6
  } ch_e;

  localparam int NUM_CH = 7;

  localparam logic [3:0] SEL_EXPRESO    = 4'b0001;
  localparam logic [3:0] SEL_CAFE_LECHE = 4'b0010;
  localparam logic [3:0] SEL_CAPPU      = 4'b0100;
  localparam logic [3:0] SEL_MOCCA      = 4'b1000;

  typedef enum logic {
    SEL_IDLE = 1'b0,
    SEL_HELD = 1'b1
  } sel_state_e;

  // Several drinks debounced in the same cycle: the lowest bit wins.
  function automatic logic [3:0] drink_priority(input logic [3:0] ev);
    logic [3:0] pick;
    pick = '0;
    if (ev[0])      pick = SEL_EXPRESO;
    else if (ev[1]) pick = SEL_CAFE_LECHE;
    else if (ev[2]) pick = SEL_CAPPU;
    else if (ev[3]) pick = SEL_MOCCA;
    return pick;
  endfunction

endpackage

// File: rtl/panel_input_conditioner_debounce.sv
// One panel input: 2-flop synchronizer, polarity normalization, stability
// counter and a registered rising-edge event on the debounced level.
module debounce_channel
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit INVERT          = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic evt,
  output logic evt_next
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          lvl;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  // Synchronizer resets to the released raw level so leaving reset with an
  // idle input never starts a spurious debounce.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= {2{INVERT}};
    else      sync <= {sync[0], raw};
  end

  assign lvl = sync[1] ^ INVERT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (lvl == stable) begin
      cnt    <= '0;
    end else if (cnt == TC) begin
      stable <= lvl;
      cnt    <= '0;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end

  assign evt_next = stable & ~stable_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_d <= 1'b0;
      evt      <= 1'b0;
    end else begin
      stable_d <= stable;
      evt      <= evt_next;
    end
  end

endmodule

// File: rtl/panel_input_conditioner.sv
// Front-panel conditioner: debounced coin/cancel pulses and a held one-hot
// drink selection handed to the coffee FSM.
//   state    | meaning
//   SEL_IDLE | no pending drink, sel = 0, sel_valid = 0
//   SEL_HELD | one drink latched in sel, waiting for sel_ack or cancel
module panel_input_conditioner
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       M1,
  input  logic       M2,
  input  logic       cancel,
  input  logic       expreso,
  input  logic       cafe_leche,
  input  logic       cappu,
  input  logic       mocca,
  input  logic       sel_ack,
  output logic       coin1_pulse,
  output logic       coin2_pulse,
  output logic       cancel_pulse,
  output logic [3:0] sel,
  output logic       sel_valid
);

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] evt;
  logic [NUM_CH-1:0] evt_next;

  assign raw[CH_M1]         = M1;
  assign raw[CH_M2]         = M2;
  assign raw[CH_CANCEL]     = cancel;
  assign raw[CH_EXPRESO]    = expreso;
  assign raw[CH_CAFE_LECHE] = cafe_leche;
  assign raw[CH_CAPPU]      = cappu;
  assign raw[CH_MOCCA]      = mocca;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT((i >= int'(CH_EXPRESO)) && (BTN_ACTIVE_LOW != 0))
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .raw      (raw[i]),
      .evt      (evt[i]),
      .evt_next (evt_next[i])
    );
  end

  logic unused_evt;
  assign unused_evt = ^{evt[CH_MOCCA], evt[CH_CAPPU], evt[CH_CAFE_LECHE],
                        evt[CH_EXPRESO], evt_next[CH_M2], evt_next[CH_M1]};

  // The FSM reacts to the event's next value so sel changes on the same edge
  // that the corresponding event register asserts.
  logic [3:0] drink_ev;
  logic       cancel_ev;

  assign drink_ev  = {evt_next[CH_MOCCA], evt_next[CH_CAPPU],
                      evt_next[CH_CAFE_LECHE], evt_next[CH_EXPRESO]};
  assign cancel_ev = evt_next[CH_CANCEL];

  sel_state_e state, state_nxt;
  logic [3:0] sel_q, sel_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SEL_IDLE;
      sel_q <= '0;
    end else begin
      state <= state_nxt;
      sel_q <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    case (state)
      SEL_IDLE: begin
        if (!cancel_ev && (|drink_ev)) begin
          state_nxt = SEL_HELD;
          sel_nxt   = drink_priority(drink_ev);
        end
      end
      SEL_HELD: begin
        if (sel_ack || cancel_ev) begin
          state_nxt = SEL_IDLE;
          sel_nxt   = '0;
        end
      end
      default: begin
        state_nxt = SEL_IDLE;
        sel_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    coin1_pulse  = evt[CH_M1];
    coin2_pulse  = evt[CH_M2];
    cancel_pulse = evt[CH_CANCEL];
    sel          = sel_q;
    sel_valid    = (state == SEL_HELD);
  end

endmodule
